// File: rtl/tx_bit_timer_if.sv
// Bus between the Tx control FSM (master) and the bit-period timer (slave).
// The master requests frames with start/div/nbits and may abort; the timer
// reports busy, per-bit tick, frame done, bit index, prescaler value and mid-bit pulse.
interface tx_bit_timer_if #(
  parameter int CNT_W = 16,
  parameter int BIT_W = 4
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] div;
  logic [BIT_W-1:0] nbits;
  logic             busy;
  logic             tick;
  logic             done;
  logic [BIT_W-1:0] bit_idx;
  logic [CNT_W-1:0] cnt;
  logic             mid;

  modport master (
    output start, abort, div, nbits,
    input  busy, tick, done, bit_idx, cnt, mid
  );

  modport slave (
    input  start, abort, div, nbits,
    output busy, tick, done, bit_idx, cnt, mid
  );
endinterface

// File: rtl/tx_bit_timer.sv
// Bit-period timer for the Tx path.
// A prescaler counts (div+1) clocks per bit and a bit-index counter counts
// (nbits+1) bits per frame. tick/done/mid are decoded combinationally from the
// registered counters so they line up with the cycle they describe.
// Optional feature macro: TX_BIT_TIMER_MID_TICK_EN enables the mid-bit pulse;
// without it the mid output is tied low and no comparator is built.
module tx_bit_timer #(
  parameter int CNT_W = 16,
  parameter int BIT_W = 4
) (
  input logic          clk,
  input logic          rst,
  tx_bit_timer_if.slave tmr
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_idx_q, bit_idx_d;
  logic [BIT_W-1:0] nbits_q, nbits_d;

  logic lastCnt;
  logic lastBit;
  logic running;
  logic tickW;
  logic doneW;

  // Decode end-of-bit and end-of-frame from the latched limits; abort masks every pulse.
  always_comb begin
    running = (state_q == RUN);
    lastCnt = (cnt_q == div_q);
    lastBit = (bit_idx_q == nbits_q);
    tickW   = running && !tmr.abort && lastCnt;
    doneW   = tickW && lastBit;
  end

  // Next-state logic: abort first, then end of bit period, otherwise count.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    bit_idx_d = bit_idx_q;
    nbits_d   = nbits_q;
    unique case (state_q)
      IDLE: begin
        if (tmr.start && !tmr.abort) begin
          state_d   = RUN;
          div_d     = tmr.div;
          nbits_d   = tmr.nbits;
          cnt_d     = '0;
          bit_idx_d = '0;
        end
      end
      RUN: begin
        if (tmr.abort) begin
          state_d   = IDLE;
          cnt_d     = '0;
          bit_idx_d = '0;
        end else if (lastCnt) begin
          cnt_d = '0;
          if (lastBit) begin
            state_d   = IDLE;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  // State and counter registers; reset returns everything to idle immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      div_q     <= '0;
      bit_idx_q <= '0;
      nbits_q   <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      bit_idx_q <= bit_idx_d;
      nbits_q   <= nbits_d;
    end
  end

  assign tmr.busy    = busy_q;
  assign tmr.tick    = tickW;
  assign tmr.done    = doneW;
  assign tmr.bit_idx = bit_idx_q;
  assign tmr.cnt     = cnt_q;

`ifdef TX_BIT_TIMER_MID_TICK_EN
  assign tmr.mid = running && !tmr.abort && (cnt_q == (div_q >> 1));
`else
  assign tmr.mid = 1'b0;
`endif

endmodule

// File: tb/tb_tx_bit_timer.sv
// Self-checking bench for tx_bit_timer.
// The reference model tracks a frame as a single run-cycle index k and derives
// prescaler value, bit index, tick and done from k with division/modulo.
// Honours TX_BIT_TIMER_MID_TICK_EN the same way the design does.
module tb_tx_bit_timer;
  localparam int CNT_W = 16;
  localparam int BIT_W = 4;

  logic clk;
  logic rst;

  tx_bit_timer_if #(.CNT_W(CNT_W), .BIT_W(BIT_W)) bus ();

  tx_bit_timer #(.CNT_W(CNT_W), .BIT_W(BIT_W)) dut (
    .clk (clk),
    .rst (rst),
    .tmr (bus.slave)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model state: frame active flag, run-cycle index, latched limits.
  int  mBusy = 0;
  int  mK = 0;
  int  mDiv = 0;
  int  mNbits = 0;

  // Observed totals accumulated per cycle, cleared per scenario.
  int  obsBusy = 0;
  int  obsTick = 0;
  int  obsDone = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare every output against the model, then advance the model.
  task automatic applyStimulus(input int s, input int a, input int d, input int n);
    int span, eCnt, eBit, eTick, eDone, eMid;
    @(posedge clk);
    #1;
    bus.start = s[0];
    bus.abort = a[0];
    bus.div   = CNT_W'(d);
    bus.nbits = BIT_W'(n);
    #1;
    span  = mDiv + 1;
    eCnt  = mBusy ? (mK % span) : 0;
    eBit  = mBusy ? (mK / span) : 0;
    eTick = (mBusy && !a && eCnt == mDiv) ? 1 : 0;
    eDone = (eTick && mK == span * (mNbits + 1) - 1) ? 1 : 0;
`ifdef TX_BIT_TIMER_MID_TICK_EN
    eMid  = (mBusy && !a && eCnt == mDiv / 2) ? 1 : 0;
`else
    eMid  = 0;
`endif
    checkOutput("busy", 32'(bus.busy), 32'(mBusy));
    checkOutput("cnt", 32'(bus.cnt), 32'(eCnt));
    checkOutput("bit_idx", 32'(bus.bit_idx), 32'(eBit));
    checkOutput("tick", 32'(bus.tick), 32'(eTick));
    checkOutput("done", 32'(bus.done), 32'(eDone));
    checkOutput("mid", 32'(bus.mid), 32'(eMid));
    if (bus.busy === 1'b1) obsBusy++;
    if (bus.tick === 1'b1) obsTick++;
    if (bus.done === 1'b1) obsDone++;
    if (mBusy != 0) begin
      if (a != 0 || eDone != 0) begin
        mBusy = 0;
        mK    = 0;
      end else begin
        mK++;
      end
    end else if (s != 0 && a == 0) begin
      mBusy  = 1;
      mK     = 0;
      mDiv   = d;
      mNbits = n;
    end
  endtask

  // Idle cycles until the DUT drops busy, bounded so a stuck design still reaches the summary.
  task automatic drainFrame(input int d, input int n);
    int guard;
    guard = 0;
    do begin
      applyStimulus(0, 0, d, n);
      guard++;
    end while (bus.busy === 1'b1 && guard < 2000);
    checkOutput("drain_timeout", 32'(guard < 2000), 32'd1);
  endtask

  task automatic clearObs();
    obsBusy = 0;
    obsTick = 0;
    obsDone = 0;
  endtask

  initial begin
    int d, n, s, a, gap;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.div   = '0;
    bus.nbits = '0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    $display("[TB] reset released");

    // Reset state seen through an idle cycle.
    applyStimulus(0, 0, 0, 0);

    // div=3, nbits=7: 32 busy cycles, 8 ticks, one done.
    clearObs();
    applyStimulus(1, 0, 3, 7);
    drainFrame(3, 7);
    checkOutput("frame32_len", 32'(obsBusy), 32'd32);
    checkOutput("frame32_ticks", 32'(obsTick), 32'd8);
    checkOutput("frame32_done", 32'(obsDone), 32'd1);

    // div=0, nbits=0 then immediate back-to-back start after done.
    clearObs();
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("tiny_busy", 32'(obsBusy), 32'd2);
    checkOutput("tiny_done", 32'(obsDone), 32'd2);

    // div=9, nbits=3 with div change and start during RUN: still 40 cycles.
    clearObs();
    applyStimulus(1, 0, 9, 3);
    repeat (4) applyStimulus(0, 0, 9, 3);
    applyStimulus(1, 0, 2, 3);
    drainFrame(2, 3);
    checkOutput("ignore_len", 32'(obsBusy), 32'd40);
    checkOutput("ignore_ticks", 32'(obsTick), 32'd4);

    // div=4, nbits=2 aborted at RUN cycle 7, then start+abort in IDLE.
    clearObs();
    applyStimulus(1, 0, 4, 2);
    repeat (6) applyStimulus(0, 0, 4, 2);
    applyStimulus(0, 1, 4, 2);
    applyStimulus(0, 0, 4, 2);
    applyStimulus(1, 1, 4, 2);
    applyStimulus(0, 0, 4, 2);
    checkOutput("abort_len", 32'(obsBusy), 32'd7);
    checkOutput("abort_done", 32'(obsDone), 32'd0);

    // Abort exactly on a tick cycle masks tick and done.
    clearObs();
    applyStimulus(1, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("abort_tick_done", 32'(obsDone), 32'd0);

    // div=5: mid at cnt=2 of every bit when the feature is built.
    clearObs();
    applyStimulus(1, 0, 5, 2);
    drainFrame(5, 2);
    checkOutput("mid_len", 32'(obsBusy), 32'd18);

    // Asynchronous reset mid-frame.
    clearObs();
    applyStimulus(1, 0, 6, 5);
    repeat (10) applyStimulus(0, 0, 6, 5);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_cnt", 32'(bus.cnt), 32'd0);
    checkOutput("rst_bit_idx", 32'(bus.bit_idx), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_tick", 32'(bus.tick), 32'd0);
    mBusy = 0;
    mK    = 0;
    mDiv  = 0;
    mNbits = 0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    repeat (3) applyStimulus(0, 0, 6, 5);

    // Randomized frames with sporadic aborts and starts while busy.
    for (int f = 0; f < 40; f++) begin
      d = $urandom_range(0, 6);
      n = $urandom_range(0, 6);
      applyStimulus(1, ($urandom_range(0, 9) == 0) ? 1 : 0, d, n);
      for (int c = 0; c < 60 && mBusy != 0; c++) begin
        s = ($urandom_range(0, 7) == 0) ? 1 : 0;
        a = ($urandom_range(0, 39) == 0) ? 1 : 0;
        applyStimulus(s, a, $urandom_range(0, 6), $urandom_range(0, 6));
      end
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) applyStimulus(0, 0, d, n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
